// File: rtl/sync_gs_receiver.sv
// Responder for the grayscale serial link: shifts SIN on SCLK edges, decodes the
// LAT width into WRTGS/LATGS commands, and exposes the GS2 display bank on a read port.
module sync_gs_receiver #(
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int SR_WIDTH          = 48,
  parameter int FRAME_CNT_WIDTH   = 8,
  localparam int IDX_W            = $clog2(NB_LEDS_PER_GROUP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCLK,
  input  logic                       SIN,
  input  logic                       LAT,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [SR_WIDTH-1:0]        rd_data,
  output logic [IDX_W-1:0]           wr_ptr,
  output logic                       wrtgs_pulse,
  output logic                       latgs_pulse,
  output logic                       cmd_err,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

  logic                prev_sclk;
  logic                prev_lat;
  logic [SR_WIDTH-1:0] sr;
  logic [2:0]          lat_cnt;

  logic                posedge_sclk;
  logic                lat_fall;
  logic [SR_WIDTH-1:0] sr_shifted;
  logic [SR_WIDTH-1:0] word;
  logic                do_wrtgs;
  logic                do_latgs;
  logic                do_err;

  logic [SR_WIDTH-1:0] gs2_words [NB_LEDS_PER_GROUP];

  always_comb begin
    posedge_sclk = SCLK & ~prev_sclk;
    lat_fall     = ~LAT & prev_lat;
    sr_shifted   = {sr[SR_WIDTH-2:0], SIN};
    // A shift landing on the decode cycle belongs to the word being written.
    word         = posedge_sclk ? sr_shifted : sr;
    do_wrtgs     = lat_fall && (lat_cnt == 3'd1);
    do_latgs     = lat_fall && (lat_cnt == 3'd3);
    do_err       = lat_fall && (lat_cnt != 3'd0) && !do_wrtgs && !do_latgs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sclk   <= 1'b0;
      prev_lat    <= 1'b0;
      sr          <= '0;
      lat_cnt     <= 3'd0;
      wr_ptr      <= '0;
      frame_cnt   <= '0;
      wrtgs_pulse <= 1'b0;
      latgs_pulse <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      prev_sclk   <= SCLK;
      prev_lat    <= LAT;
      wrtgs_pulse <= do_wrtgs;
      latgs_pulse <= do_latgs;
      cmd_err     <= do_err;
      if (posedge_sclk) sr <= sr_shifted;
      if (lat_fall) begin
        lat_cnt <= 3'd0;
      end else if (posedge_sclk && LAT && (lat_cnt != 3'd7)) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      if (do_wrtgs) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else if (do_latgs) begin
        wr_ptr <= '0;
      end
      if (do_latgs) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Per-slot GS1/GS2 storage; the slot under wr_ptr takes the new word directly on LATGS.
  for (genvar gi = 0; gi < NB_LEDS_PER_GROUP; gi++) begin : g_slot
    logic [SR_WIDTH-1:0] gs1_reg;
    logic [SR_WIDTH-1:0] gs2_reg;
    logic                hit;

    assign hit           = (wr_ptr == IDX_W'(gi));
    assign gs2_words[gi] = gs2_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gs1_reg <= '0;
        gs2_reg <= '0;
      end else begin
        if ((do_wrtgs || do_latgs) && hit) gs1_reg <= word;
        if (do_latgs) gs2_reg <= hit ? word : gs1_reg;
      end
    end
  end

  assign rd_data = gs2_words[rd_idx];

endmodule

// File: tb/tb_sync_gs_receiver.sv
// Directed bench for sync_gs_receiver: serial word loads, WRTGS/LATGS/error decode,
// LAT glitches and asynchronous reset in the middle of a command window.
module tb_sync_gs_receiver;
  localparam int N  = 16;
  localparam int W  = 48;
  localparam int FW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          SCLK = 1'b0;
  logic          SIN = 1'b0;
  logic          LAT = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  logic [W-1:0]  rd_data;
  logic [IW-1:0] wr_ptr;
  logic          wrtgs_pulse;
  logic          latgs_pulse;
  logic          cmd_err;
  logic [FW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  sync_gs_receiver #(
    .NB_LEDS_PER_GROUP(N),
    .SR_WIDTH(W),
    .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SCLK(SCLK),
    .SIN(SIN),
    .LAT(LAT),
    .rd_idx(rd_idx),
    .rd_data(rd_data),
    .wr_ptr(wr_ptr),
    .wrtgs_pulse(wrtgs_pulse),
    .latgs_pulse(latgs_pulse),
    .cmd_err(cmd_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int base, input int i);
    logic [15:0] v;
    v = 16'(base + i);
    return {v, v, v};
  endfunction

  // Shifts w MSB first; LAT is high for the last nlat SCLK edges, then drops.
  // Returns #1 after the clk edge that decodes the LAT fall.
  task automatic send_word(input logic [W-1:0] w, input int nlat);
    for (int i = W - 1; i >= 0; i--) begin
      SIN  = w[i];
      LAT  = (i < nlat);
      SCLK = 1'b1;
      @(posedge clk); #1;
      SCLK = 1'b0;
      @(posedge clk); #1;
    end
    LAT = 1'b0;
    @(posedge clk); #1;
    $display("word %h nlat %0d -> wr_ptr %0d frame %0d", w, nlat, wr_ptr, frame_cnt);
  endtask

  task automatic check_pulses(input string tag, input logic w, input logic l, input logic e);
    check_eq({tag, "_wrtgs"}, wrtgs_pulse, w);
    check_eq({tag, "_latgs"}, latgs_pulse, l);
    check_eq({tag, "_err"}, cmd_err, e);
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, {wrtgs_pulse, latgs_pulse, cmd_err}, 3'b000);
  endtask

  task automatic check_rd(input string tag, input int idx, input logic [W-1:0] exp);
    rd_idx = IW'(idx);
    #1;
    check_eq(tag, rd_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wr_ptr", wr_ptr, 0);
    check_eq("rst_frame", frame_cnt, 0);
    check_eq("rst_rd", rd_data, 0);
    check_eq("rst_pulses", {wrtgs_pulse, latgs_pulse, cmd_err}, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single WRTGS into slot 0
    send_word(48'hA5A5_0F0F_1234, 1);
    check_pulses("t1", 1'b1, 1'b0, 1'b0);
    check_eq("t1_wr_ptr", wr_ptr, 1);
    check_rd("t1_gs2_still0", 0, '0);

    // Fill slots 1..15 and latch, exposing GS1[0] through GS2
    for (int i = 1; i < 15; i++) send_word(word_of(16'h0300, i), 1);
    send_word(word_of(16'h0300, 15), 3);
    check_pulses("fill", 1'b0, 1'b1, 1'b0);
    check_rd("fill_gs2_0", 0, 48'hA5A5_0F0F_1234);
    check_rd("fill_gs2_7", 7, word_of(16'h0300, 7));
    check_rd("fill_gs2_15", 15, word_of(16'h0300, 15));
    check_eq("fill_frame", frame_cnt, 1);
    check_eq("fill_wr_ptr", wr_ptr, 0);

    // Full 16-word frame
    for (int i = 0; i < 15; i++) send_word(word_of(16'h0100, i), 1);
    check_eq("t2_wr_ptr15", wr_ptr, 15);
    send_word(word_of(16'h0100, 15), 3);
    check_pulses("t2", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) check_rd($sformatf("t2_gs2_%0d", i), i, word_of(16'h0100, i));
    check_eq("t2_wr_ptr", wr_ptr, 0);
    check_eq("t2_frame", frame_cnt, 2);

    // Unsupported widths
    send_word(48'hDEAD_BEEF_0001, 2);
    check_pulses("t3a", 1'b0, 1'b0, 1'b1);
    check_eq("t3a_wr_ptr", wr_ptr, 0);
    check_rd("t3a_gs2_3", 3, word_of(16'h0100, 3));
    send_word(48'hDEAD_BEEF_0002, 5);
    check_pulses("t3b", 1'b0, 1'b0, 1'b1);
    check_eq("t3b_wr_ptr", wr_ptr, 0);
    check_rd("t3b_gs2_0", 0, word_of(16'h0100, 0));
    check_eq("t3_frame", frame_cnt, 2);

    // 17 WRTGS wrap wr_ptr and overwrite slot 0, then LATGS into slot 1
    for (int k = 0; k <= 16; k++) send_word(48'(k), 1);
    check_eq("t4_wr_ptr_wrap", wr_ptr, 1);
    send_word(48'd99, 3);
    check_pulses("t4", 1'b0, 1'b1, 1'b0);
    check_rd("t4_gs2_1", 1, 48'd99);
    check_rd("t4_gs2_0", 0, 48'd16);
    check_rd("t4_gs2_2", 2, 48'd2);
    check_rd("t4_gs2_15", 15, 48'd15);
    check_eq("t4_wr_ptr", wr_ptr, 0);
    check_eq("t4_frame", frame_cnt, 3);

    // LAT glitch without SCLK edges
    LAT = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    LAT = 1'b0;
    @(posedge clk); #1;
    check_pulses("t5_glitch", 1'b0, 1'b0, 1'b0);
    check_eq("t5_glitch_wr_ptr", wr_ptr, 0);
    send_word(48'h1111_2222_3333, 1);
    check_pulses("t5", 1'b1, 1'b0, 1'b0);
    check_eq("t5_wr_ptr", wr_ptr, 1);

    // Asynchronous reset in the middle of a LATGS LAT window
    rd_idx = IW'(1);
    for (int i = W - 1; i >= 1; i--) begin
      SIN  = 1'b1;
      LAT  = (i < 3);
      SCLK = 1'b1;
      @(posedge clk); #1;
      SCLK = 1'b0;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_wr_ptr", wr_ptr, 0);
    check_eq("t6_rst_frame", frame_cnt, 0);
    check_eq("t6_rst_rd", rd_data, 0);
    check_eq("t6_rst_pulses", {wrtgs_pulse, latgs_pulse, cmd_err}, 3'b000);
    @(posedge clk); #1;
    SCLK = 1'b0;
    SIN  = 1'b0;
    LAT  = 1'b0;
    rst  = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) send_word(word_of(16'h0200, i), 1);
    send_word(word_of(16'h0200, 15), 3);
    check_pulses("t6", 1'b0, 1'b1, 1'b0);
    check_eq("t6_frame", frame_cnt, 1);
    check_eq("t6_wr_ptr", wr_ptr, 0);
    check_rd("t6_gs2_0", 0, word_of(16'h0200, 0));
    check_rd("t6_gs2_5", 5, word_of(16'h0200, 5));
    check_rd("t6_gs2_15", 15, word_of(16'h0200, 15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
